mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencer for the CPU's single shared memory port. Arbitrates between the instruction-fetch requester (port 0) and the load/store requester (port 1), drives the select line of the external 2:1 32-bit address mux, and times each access over a fixed memory latency. It returns a one-cycle completion pulse and registered read data to the granted requester.

## Interface
- `MEM_LAT`, default 2: memory access latency in cycles, ≥1.
- `CNT_W`, default 4: latency counter width; requires `MEM_LAT` ≤ 2^`CNT_W`.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  fetch request, port 0. Read-only.
- `req1`  in  1  data request, port 1.
- `we1`  in  1  port 1 write enable, sampled at grant.
- `mem_rdata`  in  32  memory read data.
- `sel`  out  1  address-mux select: 0 = port 0, 1 = port 1.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write strobe.
- `ack0`  out  1  port 0 completion pulse.
- `ack1`  out  1  port 1 completion pulse.
- `rdata`  out  32  registered read data.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states.
  - IDLE → ACCESS when `req0` or `req1` is sampled high.
  - ACCESS → DONE when `cnt` == 0; otherwise `cnt` decrements by 1.
  - DONE → IDLE, unconditionally.
- Requests are sampled only in IDLE. In ACCESS and DONE they are ignored.
- Arbitration uses round-robin with a `last` register.
  - If only one request is high, that port is granted.
  - If both are high, the grant goes to `~last`.
  - `last` is updated to the grant on the IDLE→ACCESS edge.
- On grant the block registers:
  - `sel` ← grant.
  - `wr` ← `we1` & grant. Port 0 never writes.
  - `cnt` ← `MEM_LAT`−1.
- Outputs in ACCESS: `mem_en` = 1 and `mem_we` = `wr`.
- Read completion: on the ACCESS→DONE edge, if `wr` = 0, then `rdata` ← `mem_rdata`.
- Write completion: `rdata` is unchanged.
- In DONE, `ack0`/`ack1` = 1 for the granted port only. `mem_en` = `mem_we` = 0.
- `sel` holds the grant through ACCESS and DONE, and is 0 in IDLE.
- Requester protocol:
  - The requester holds `req`, and for port 1 also `we1`, until its ack.
  - It drops `req` no later than the cycle after the ack. Otherwise the request is re-serviced as a new transaction.
  - Dropping `req` mid-ACCESS does not abort the transaction; the ack still fires.
- Reset values:
  - state = IDLE, `cnt` = 0, `last` = 1 (so fetch wins the first tie).
  - `sel`, `mem_en`, `mem_we`, `ack0`, `ack1`, `busy` = 0; `rdata` = 0.
- Reset during ACCESS or DONE aborts the transaction with no ack, and `mem_en` is 0 on the next cycle.

## Timing
- Request high in IDLE at cycle 0:
  - ACCESS occupies cycles 1..`MEM_LAT`.
  - DONE and the ack occur at cycle `MEM_LAT`+1.
  - IDLE resumes at cycle `MEM_LAT`+2.
- Memory contract: `mem_rdata` must be valid in the last ACCESS cycle (cycle `MEM_LAT`).
- Peak throughput is one transaction per `MEM_LAT`+2 cycles.
- `ack0` and `ack1` are never high together.
- `mem_we` is never high outside ACCESS.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encoding: `S_IDLE` = 2'd0, `S_ACCESS` = 2'd1, `S_DONE` = 2'd2.
  - port IDs: `PORT_FETCH` = 1'b0, `PORT_DATA` = 1'b1.
- One sub-module, `lat_counter`, is natural: a loadable down-counter with `load`, `load_val` and `zero` outputs.
- The address and write-data muxes stay outside this block and are driven by `sel`.

## Test plan
- Reset, then idle for 10 cycles → all outputs 0, `busy` = 0.
- `MEM_LAT` = 2, `req0` pulse held, `mem_rdata` = 32'hDEADBEEF → `sel` = 0, `mem_en` high for cycles 1–2, `ack0` at cycle 3, `rdata` = 32'hDEADBEEF, IDLE at cycle 4.
- `req0` and `req1` high from reset and each re-requested after every ack → grants alternate 0,1,0,1; first grant is port 0.
- `req1` with `we1` = 1 → `mem_we` high exactly in the ACCESS cycles with `sel` = 1, `ack1` fires, `rdata` unchanged from its prior value.
- `req1` dropped at cycle 1 of ACCESS → access completes, `ack1` still at cycle `MEM_LAT`+1.
- `rst` asserted at cycle 1 of ACCESS → next cycle in IDLE, no ack, `mem_en` = 0, `last` = 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    // Round-robin pick: a tie goes to the port that did not win last time.
    function automatic logic rr_grant(input logic req0, input logic req1, input logic last);
        logic g;
        if (req0 && req1) g = ~last;
        else if (req1)    g = PORT_DATA;
        else              g = PORT_FETCH;
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times one memory access; zero flags terminal count.
module lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared memory-port sequencer: round-robin grant between fetch and load/store,
// fixed-latency access, one-cycle ack and registered read data.
//
// state    | meaning
// S_IDLE   | waiting for a request; requests sampled only here
// S_ACCESS | memory enabled, latency counter running
// S_DONE   | ack to granted port, read data already captured
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we1,
    input  logic [31:0] i_mem_rdata,
    output logic        o_sel,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic        o_ack0,
    output logic        o_ack1,
    output logic [31:0] o_rdata,
    output logic        o_busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_sel;
    logic        r_wr;
    logic        r_last;
    logic [31:0] r_rdata;
    logic        w_start;
    logic        w_grant;
    logic        w_zero;
    logic        w_capture;

    assign w_start   = (r_state == S_IDLE) && (i_req0 || i_req1);
    assign w_grant   = rr_grant(i_req0, i_req1, r_last);
    assign w_capture = (r_state == S_ACCESS) && w_zero && !r_wr;

    lat_counter #(.CNT_W(CNT_W)) u_lat_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_start),
        .i_load_val (LOAD_VAL),
        .i_dec      (r_state == S_ACCESS),
        .o_zero     (w_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel   <= PORT_FETCH;
            r_wr    <= 1'b0;
            r_last  <= PORT_DATA;
            r_rdata <= '0;
        end else begin
            if (w_start) begin
                r_sel  <= w_grant;
                r_wr   <= i_we1 & w_grant;
                r_last <= w_grant;
            end
            if (w_capture) begin
                r_rdata <= i_mem_rdata;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        o_sel    = 1'b0;
        o_mem_en = 1'b0;
        o_mem_we = 1'b0;
        o_ack0   = 1'b0;
        o_ack1   = 1'b0;
        o_busy   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                o_sel    = r_sel;
                o_mem_en = 1'b1;
                o_mem_we = r_wr;
                o_busy   = 1'b1;
                if (w_zero) w_next = S_DONE;
            end
            S_DONE: begin
                o_sel  = r_sel;
                o_ack0 = (r_sel == PORT_FETCH);
                o_ack1 = (r_sel == PORT_DATA);
                o_busy = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized requesters driving the arbiter; a scoreboard of expected
// transactions is checked cycle by cycle by an independent monitor.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;
    localparam int NSLOT   = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we1;
    logic [31:0] mem_rdata;
    logic        sel, mem_en, mem_we, ack0, ack1, busy;
    logic [31:0] rdata;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .CNT_W(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we1       (we1),
        .i_mem_rdata (mem_rdata),
        .o_sel       (sel),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_ack0      (ack0),
        .o_ack1      (ack1),
        .o_rdata     (rdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          issue;
        logic        port;
        logic        we;
        logic [31:0] exp_rdata;
    } txn_t;

    txn_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          mon_on   = 0;
    logic [31:0] committed = '0;

    // requester / reference-model state
    bit          p0 = 0, p1 = 0, wev = 0;
    bit          last = 1;
    logic [31:0] model_rdata = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_cycle();
        logic [5:0] exp_v, act_v;
        txn_t t;
        exp_v = '0;
        if (sb.size() > 0) begin
            t = sb[0];
            if (cyc >= t.issue + 1 && cyc <= t.issue + MEM_LAT)
                exp_v = {1'b1, t.port, 1'b1, t.we, 1'b0, 1'b0};
            else if (cyc == t.issue + MEM_LAT + 1) begin
                exp_v = {1'b1, t.port, 1'b0, 1'b0, ~t.port, t.port};
                committed = t.exp_rdata;
                void'(sb.pop_front());
            end
        end
        act_v = {busy, sel, mem_en, mem_we, ack0, ack1};
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL ctrl cyc=%0d {busy,sel,en,we,ack0,ack1} got=%b want=%b", cyc, act_v, exp_v);
        end
        checks++;
        if (rdata !== committed) begin
            failures++;
            $display("FAIL rdata cyc=%0d got=%h want=%h", cyc, rdata, committed);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_on) check_cycle();
        end
    end

    task automatic run_slot(input bit force_both);
        bit          g, w, drop_mid;
        logic [31:0] data;
        if (!p0 && (force_both || $urandom_range(0, 2) != 0)) p0 = 1;
        if (!p1 && (force_both || $urandom_range(0, 2) != 0)) begin
            p1  = 1;
            wev = 1'($urandom_range(0, 1));
        end
        req0 = p0;
        req1 = p1;
        we1  = wev;
        if (!p0 && !p1) begin
            @(negedge clk);
            return;
        end
        g    = (p0 && p1) ? ~last : p1;
        last = g;
        w    = g & wev;
        data = $urandom;
        if (!w) model_rdata = data;
        sb.push_back(txn_t'{issue: cyc, port: g, we: w, exp_rdata: model_rdata});
        drop_mid = ($urandom_range(0, 4) == 0);
        for (int c = 1; c <= MEM_LAT + 1; c++) begin
            @(negedge clk);
            mem_rdata = (c == MEM_LAT) ? data : $urandom;
            if ((c == 1 && drop_mid) || c == MEM_LAT + 1) begin
                if (g) begin p1 = 0; req1 = 0; end
                else   begin p0 = 0; req0 = 0; end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; req0 = 0; req1 = 0; we1 = 0; mem_rdata = $urandom;
        @(posedge clk);
        mon_on = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);

        // first slot is a tie: fetch must win, then alternation follows
        run_slot(1);
        run_slot(1);
        run_slot(1);
        for (int s = 0; s < NSLOT; s++) run_slot(0);

        // make sure a real read has landed so the reset clear is visible
        p0 = 1; p1 = 0;
        run_slot(0);
        while (p0 || p1) run_slot(0);

        // abort mid-ACCESS with reset
        req0 = 1; req1 = 1; we1 = 0; p0 = 1; p1 = 1; wev = 0;
        sb.push_back(txn_t'{issue: cyc, port: ~last, we: 1'b0, exp_rdata: model_rdata});
        @(negedge clk);
        rst = 1; req0 = 0; req1 = 0; p0 = 0; p1 = 0;
        @(posedge clk);
        sb.delete();
        last = 1; model_rdata = '0; committed = '0;
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        run_slot(1);
        while (p0 || p1) run_slot(0);
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
